neuron_mac_seq: RTL and testbench

Parametrised fixed-point neuron with N_INPUTS inputs. It uses one shared multiplier in a time-multiplexed multiply-accumulate loop, with a saturating accumulator and a runtime-selectable activation (linear, ReLU or saturate). Weights are initialised from parameters and can be rewritten at runtime. It drops into the layer wrappers in place of the fixed six-input neurons, using the same En/Run/Ready control.

---
 rtl/neuron_mac_seq.sv | 192 +++++++++++++++++++
 tb/tb_neuron_mac_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//   Fixed-point neuron with N_INPUTS inputs. One multiplier is reused across
//   N_INPUTS cycles in a multiply-accumulate loop. The accumulator saturates,
//   and the result goes through a selectable activation (linear, ReLU or
//   saturate-to-DATA_WIDTH). Weights reset to W_INIT and can be rewritten
//   while the neuron is idle.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   En       : clock enable; low freezes every register
//   Run      : start request, sampled only in IDLE
//   X        : packed signed inputs, X[i] = X[i*DATA_WIDTH +: DATA_WIDTH]
//   act_mode : 00 linear, 01 ReLU, 10 saturate, 11 linear
//   w_we     : weight write strobe (IDLE only)
//   w_addr   : weight index; out-of-range indices are ignored
//   w_data   : signed weight value
//   Y        : signed result, held until the next result
//   Ready    : one-cycle pulse when Y updates
//   Busy     : high while a computation is in flight
//   Ovf      : accumulator saturated during the last computation
module neuron_mac_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int N_INPUTS   = 6,
   parameter int ACC_WIDTH  = DATA_WIDTH + 6,
   parameter logic [N_INPUTS*DATA_WIDTH-1:0] W_INIT =
      {8'd10, 8'd6, 8'd3, 8'd9, 8'hF6, 8'd5},
   parameter logic signed [ACC_WIDTH-1:0] BIAS = ACC_WIDTH'(-12),
   localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             En,
   input  logic                             Run,
   input  logic [N_INPUTS*DATA_WIDTH-1:0]   X,
   input  logic [1:0]                       act_mode,
   input  logic                             w_we,
   input  logic [AW-1:0]                    w_addr,
   input  logic signed [DATA_WIDTH-1:0]     w_data,
   output logic signed [ACC_WIDTH-1:0]      Y,
   output logic                             Ready,
   output logic                             Busy,
   output logic                             Ovf
);

   localparam int DW = DATA_WIDTH;
   localparam int PW = 2 * DATA_WIDTH;
   // Sum width: wide enough for either operand plus one carry bit.
   localparam int SW = ((PW > ACC_WIDTH) ? PW : ACC_WIDTH) + 1;

   localparam logic signed [SW-1:0] SUM_MAX =
      {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] SUM_MIN =
      {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_HI =
      {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_LO =
      {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);
   localparam logic [AW:0]   N_LIM    = (AW+1)'(N_INPUTS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_MAC    = 3'd2,
      S_ACT    = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   state_t                        state_q;
   logic signed [DW-1:0]          w_q  [N_INPUTS];
   logic signed [DW-1:0]          xr_q [N_INPUTS];
   logic signed [DW-1:0]          x_vec [N_INPUTS];
   logic signed [ACC_WIDTH-1:0]   acc_q;
   logic [AW-1:0]                 idx_q;
   logic signed [ACC_WIDTH-1:0]   y_q;
   logic                          ready_q;
   logic                          ovf_q;

   genvar gi;
   generate
      for (gi = 0; gi < N_INPUTS; gi++) begin : g_unpack
         assign x_vec[gi] = X[gi*DW +: DW];
      end
   endgenerate

   // ---------------- MAC datapath ----------------
   logic signed [DW-1:0]        xr_sel, w_sel;
   logic signed [PW-1:0]        prod, prod_sh;
   logic signed [SW-1:0]        sum_w;
   logic signed [ACC_WIDTH-1:0] acc_d;
   logic                        clamp_d;

   assign xr_sel  = xr_q[idx_q];
   assign w_sel   = w_q[idx_q];
   assign prod    = $signed({{DW{xr_sel[DW-1]}}, xr_sel}) *
                    $signed({{DW{w_sel[DW-1]}}, w_sel});
   assign prod_sh = prod >>> FRAC_BITS;   // floor toward -inf
   assign sum_w   = $signed({{(SW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q}) +
                    $signed({{(SW-PW){prod_sh[PW-1]}}, prod_sh});

   always_comb begin
      acc_d   = sum_w[ACC_WIDTH-1:0];
      clamp_d = 1'b0;
      if (sum_w > SUM_MAX) begin
         acc_d   = SUM_MAX[ACC_WIDTH-1:0];
         clamp_d = 1'b1;
      end else if (sum_w < SUM_MIN) begin
         acc_d   = SUM_MIN[ACC_WIDTH-1:0];
         clamp_d = 1'b1;
      end
   end

   // ---------------- Activation ----------------
   logic signed [ACC_WIDTH-1:0] act_d;

   always_comb begin
      act_d = acc_q;
      case (act_mode)
         2'b01: if (acc_q < 0) act_d = '0;
         2'b10: begin
            if (acc_q > SAT_HI)      act_d = SAT_HI;
            else if (acc_q < SAT_LO) act_d = SAT_LO;
         end
         default: act_d = acc_q;
      endcase
   end

   // ---------------- Weight store ----------------
   logic w_addr_ok;
   assign w_addr_ok = ({1'b0, w_addr} < N_LIM);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_INPUTS; i++) w_q[i] <= W_INIT[i*DW +: DW];
      end else if (En && (state_q == S_IDLE) && w_we && w_addr_ok) begin
         for (int i = 0; i < N_INPUTS; i++)
            if (w_addr == AW'(i)) w_q[i] <= w_data;
      end
   end

   // ---------------- Control FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         idx_q   <= '0;
         y_q     <= '0;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < N_INPUTS; i++) xr_q[i] <= '0;
      end else if (En) begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: if (Run) state_q <= S_LOAD;
            S_LOAD: begin
               for (int i = 0; i < N_INPUTS; i++) xr_q[i] <= x_vec[i];
               acc_q   <= BIAS;
               idx_q   <= '0;
               ovf_q   <= 1'b0;
               state_q <= S_MAC;
            end
            S_MAC: begin
               acc_q <= acc_d;
               if (clamp_d) ovf_q <= 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= S_ACT;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            // Result is registered here so Y and Ready are both valid
            // during the RESULT cycle.
            S_ACT: begin
               y_q     <= act_d;
               ready_q <= 1'b1;
               state_q <= S_RESULT;
            end
            S_RESULT: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign Y     = y_q;
   assign Ready = ready_q;
   assign Busy  = (state_q != S_IDLE);
   assign Ovf   = ovf_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed testbench for neuron_mac_seq. Instance dut uses the default
// parameters; dut12 uses ACC_WIDTH=12 to exercise accumulator saturation.
module tb_neuron_mac_seq;

   logic               clk = 1'b0;
   logic               rst, en;
   logic               run1, run2;
   logic [47:0]        x1, x2;
   logic [1:0]         act1, act2;
   logic               we1, we2;
   logic [2:0]         addr1, addr2;
   logic signed [7:0]  data1, data2;
   logic signed [13:0] y1;
   logic signed [11:0] y2;
   logic               rdy1, rdy2, busy1, busy2, ovf1, ovf2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   neuron_mac_seq dut (
      .clk(clk), .rst(rst), .En(en), .Run(run1), .X(x1), .act_mode(act1),
      .w_we(we1), .w_addr(addr1), .w_data(data1),
      .Y(y1), .Ready(rdy1), .Busy(busy1), .Ovf(ovf1)
   );

   neuron_mac_seq #(.ACC_WIDTH(12)) dut12 (
      .clk(clk), .rst(rst), .En(en), .Run(run2), .X(x2), .act_mode(act2),
      .w_we(we2), .w_addr(addr2), .w_data(data2),
      .Y(y2), .Ready(rdy2), .Busy(busy2), .Ovf(ovf2)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_x(input bit sel, input int v);
      logic [7:0] b;
      b = v[7:0];
      for (int i = 0; i < 6; i++) begin
         if (sel) x2[i*8 +: 8] = b;
         else     x1[i*8 +: 8] = b;
      end
   endtask

   task automatic wr(input bit sel, input int a, input int d);
      logic [2:0] av;
      logic [7:0] dv;
      av = a[2:0];
      dv = d[7:0];
      if (sel) begin we2 = 1'b1; addr2 = av; data2 = dv; end
      else     begin we1 = 1'b1; addr1 = av; data1 = dv; end
      @(posedge clk); #1;
      we1 = 1'b0; we2 = 1'b0;
      $display("write dut%0d W[%0d]=%0d", sel ? 12 : 14, a, d);
   endtask

   // Pulses Run, waits (bounded) for Ready. cyc counts edges from the
   // sampling edge up to the one after which Ready is observed high.
   task automatic run_op(input bit sel, input logic [1:0] mode,
                         input int gap_at, input bit midwr,
                         output int cyc, output int yv, output int ov);
      int n;
      bit r;
      if (sel) begin act2 = mode; run2 = 1'b1; end
      else     begin act1 = mode; run1 = 1'b1; end
      @(posedge clk); #1;
      run1 = 1'b0; run2 = 1'b0;
      n = 1;
      check("busy_load", sel ? int'(busy2) : int'(busy1), 1);
      r = sel ? rdy2 : rdy1;
      while (!r && n < 40) begin
         if (midwr && n == 3) begin we1 = 1'b1; addr1 = 3'd1; data1 = 8'sd50; end
         if (gap_at > 0 && n == gap_at)     en = 1'b0;
         if (gap_at > 0 && n == gap_at + 3) en = 1'b1;
         @(posedge clk); #1;
         n++;
         we1 = 1'b0;
         r = sel ? rdy2 : rdy1;
      end
      en  = 1'b1;
      cyc = n;
      yv  = sel ? int'(y2) : int'(y1);
      ov  = sel ? int'(ovf2) : int'(ovf1);
      $display("run dut%0d mode=%0d: y=%0d ovf=%0d cycles=%0d",
               sel ? 12 : 14, mode, yv, ov, cyc);
      @(posedge clk); #1;
      check("ready_one_cycle", sel ? int'(rdy2) : int'(rdy1), 0);
      check("busy_idle", sel ? int'(busy2) : int'(busy1), 0);
      check("y_held", sel ? int'(y2) : int'(y1), yv);
   endtask

   initial begin
      int cyc, yv, ov, pulses;
      rst = 1'b0; en = 1'b1;
      run1 = 1'b0; run2 = 1'b0;
      x1 = '0; x2 = '0; act1 = 2'b00; act2 = 2'b00;
      we1 = 1'b0; we2 = 1'b0; addr1 = '0; addr2 = '0; data1 = '0; data2 = '0;

      #12;
      check("rst_y", int'(y1), 0);
      check("rst_ready", int'(rdy1), 0);
      check("rst_busy", int'(busy1), 0);
      check("rst_ovf", int'(ovf1), 0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;

      // Default weights, X = 1.0
      set_x(0, 16);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("lat_x16", cyc, 9);
      check("y_x16", yv, 11);
      check("ovf_x16", ov, 0);

      set_x(0, -16);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_neg_lin", yv, -35);
      run_op(0, 2'b01, 0, 0, cyc, yv, ov);
      check("y_neg_relu", yv, 0);

      set_x(0, 127);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_127_lin", yv, 167);
      run_op(0, 2'b10, 0, 0, cyc, yv, ov);
      check("y_127_sat", yv, 127);
      run_op(0, 2'b11, 0, 0, cyc, yv, ov);
      check("y_127_mode3", yv, 167);
      run_op(0, 2'b01, 0, 0, cyc, yv, ov);
      check("y_127_relu", yv, 167);

      set_x(0, -128);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_m128_lin", yv, -196);
      run_op(0, 2'b10, 0, 0, cyc, yv, ov);
      check("y_m128_sat", yv, -128);

      // Weight writes
      wr(0, 1, 0);
      set_x(0, 16);
      run_op(0, 2'b00, 0, 1, cyc, yv, ov);
      check("y_w1_zero", yv, 21);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_mac_write_ignored", yv, 21);
      wr(0, 7, 100);
      wr(0, 6, 100);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_bad_addr_ignored", yv, 21);

      // Write in the same cycle as Run: W0 5 -> 0
      we1 = 1'b1; addr1 = 3'd0; data1 = 8'sd0;
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_write_with_run", yv, 16);

      // Accumulator saturation in the 12-bit instance
      for (int i = 0; i < 6; i++) wr(1, i, -128);
      set_x(1, -128);
      run_op(1, 2'b00, 0, 0, cyc, yv, ov);
      check("lat_acc12", cyc, 9);
      check("y_acc12_clamp", yv, 2047);
      check("ovf_acc12", ov, 1);
      set_x(1, 16);
      run_op(1, 2'b00, 0, 0, cyc, yv, ov);
      check("y_acc12_x16", yv, -780);
      check("ovf_acc12_clear", ov, 0);

      // Reset in the middle of MAC
      set_x(0, 16);
      run1 = 1'b1;
      @(posedge clk); #1 run1 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_y", int'(y1), 0);
      check("midrst_ready", int'(rdy1), 0);
      check("midrst_busy", int'(busy1), 0);
      @(posedge clk); #1 rst = 1'b1;
      pulses = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (rdy1) pulses++;
      end
      check("midrst_no_ready", pulses, 0);
      $display("reset mid-MAC: ready pulses afterwards=%0d", pulses);
      run_op(0, 2'b00, 0, 0, cyc, yv, ov);
      check("y_winit_restored", yv, 11);

      // Enable dropped for 3 cycles during MAC
      run_op(0, 2'b00, 4, 0, cyc, yv, ov);
      check("lat_en_gap", cyc, 12);
      check("y_en_gap", yv, 11);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
